// File: rtl/sa_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa_feeder_pkg
// Brief    : Shared types and constants for the 3x3 systolic-array feeder.
// Revision : 1.0  initial release
// ============================================================================
package sa_feeder_pkg;

    // Array dimension: the feeder serves a 3x3 array.
    localparam int c_N           = 3;
    // Weight preload takes one cycle per row.
    localparam int c_LOAD_CYCLES = c_N;
    // Skewed activation feed: N rows plus N-1 cycles of skew.
    localparam int c_FEED_CYCLES = 2 * c_N - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_FEED_A = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sa_skew_lane.sv
`default_nettype none
// ============================================================================
// Module   : sa_skew_lane
// Brief    : DW-wide delay chain of DEPTH stages (0 = pass-through) with
//            asynchronous active-low clear; skews one activation lane.
// Revision : 1.0  initial release
// ============================================================================
module sa_skew_lane #(
    parameter int DW    = 8,
    parameter int DEPTH = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Lane 1 needs no skew; the clock and clear are not used here.
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst};
            assign dout     = din;
        end else begin : g_chain
            logic [DW-1:0] r_stage [DEPTH];

            // Shift register: each stage delays the lane by one cycle.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sa_feeder.sv
`default_nettype none
// ============================================================================
// Module   : sa_feeder
// Brief    : Sequences one 3x3 job into a systolic array: captures W and A,
//            preloads weights row by row, then feeds column-skewed
//            activations, drains and pulses done. All outputs registered.
// Revision : 1.0  initial release
// ============================================================================
module sa_feeder
    import sa_feeder_pkg::*;
#(
    parameter int DW           = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [9*DW-1:0] w_flat,
    input  logic [9*DW-1:0] a_flat,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   B_out_1,
    output logic [DW-1:0]   B_out_2,
    output logic [DW-1:0]   B_out_3,
    output logic            P1_en,
    output logic [DW-1:0]   A_out_1,
    output logic [DW-1:0]   A_out_2,
    output logic [DW-1:0]   A_out_3
);

    // One phase counter serves LOAD_W, FEED_A and DRAIN.
    localparam int c_CNT_MAX = (DRAIN_CYCLES > c_FEED_CYCLES) ? DRAIN_CYCLES : c_FEED_CYCLES;
    localparam int c_CW      = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic [9*DW-1:0]   r_w_cap;
    logic [9*DW-1:0]   r_a_cap;
    logic [9*DW-1:0]   w_w_src;
    int                w_row;

    logic              r_busy;
    logic              r_done;
    logic              r_p1_en;
    logic [DW-1:0]     r_b    [c_N];
    logic [DW-1:0]     r_feed [c_N];
    logic [DW-1:0]     w_a_lane [c_N];

    // State and phase counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and next-phase logic; the counter restarts at 0 on every state change.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                if (r_cnt == c_CW'(c_LOAD_CYCLES - 1)) w_state_nxt = ST_FEED_A;
                else                                   w_cnt_nxt   = r_cnt + c_CW'(1);
            end
            ST_FEED_A: begin
                if (r_cnt == c_CW'(c_FEED_CYCLES - 1))
                    w_state_nxt = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                else
                    w_cnt_nxt = r_cnt + c_CW'(1);
            end
            ST_DRAIN: begin
                if (r_cnt == c_CW'(DRAIN_CYCLES - 1)) w_state_nxt = ST_DONE;
                else                                  w_cnt_nxt   = r_cnt + c_CW'(1);
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Matrix capture: only an accepted start in IDLE updates the copies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w_cap <= '0;
            r_a_cap <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_w_cap <= w_flat;
            r_a_cap <= a_flat;
        end
    end

    // The first LOAD_W row is registered on the same edge that captures W,
    // so that row must come straight from the input bus.
    always_comb begin
        w_w_src = (r_state == ST_IDLE) ? w_flat : r_w_cap;
        w_row   = (w_cnt_nxt < c_CW'(c_N)) ? int'(w_cnt_nxt) : 0;
    end

    // Output registers loaded from the upcoming state so values line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p1_en <= 1'b0;
            for (int k = 0; k < c_N; k++) begin
                r_b[k]    <= '0;
                r_feed[k] <= '0;
            end
        end else begin
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);
            r_p1_en <= (w_state_nxt == ST_LOAD_W);
            for (int k = 0; k < c_N; k++) begin
                r_b[k] <= (w_state_nxt == ST_LOAD_W)
                          ? w_w_src[(w_row * c_N + k) * DW +: DW] : '0;
                // Unskewed column stream: row t of A while t < N, else zero.
                r_feed[k] <= (w_state_nxt == ST_FEED_A && w_cnt_nxt < c_CW'(c_N))
                             ? r_a_cap[(w_row * c_N + k) * DW +: DW] : '0;
            end
        end
    end

    generate
        for (genvar k = 0; k < c_N; k++) begin : g_lane
            sa_skew_lane #(
                .DW    (DW),
                .DEPTH (k)
            ) u_skew (
                .clk  (clk),
                .rst  (rst),
                .din  (r_feed[k]),
                .dout (w_a_lane[k])
            );
        end
    endgenerate

    assign busy    = r_busy;
    assign done    = r_done;
    assign P1_en   = r_p1_en;
    assign B_out_1 = r_b[0];
    assign B_out_2 = r_b[1];
    assign B_out_3 = r_b[2];
    assign A_out_1 = w_a_lane[0];
    assign A_out_2 = w_a_lane[1];
    assign A_out_3 = w_a_lane[2];

endmodule
`default_nettype wire

// File: doc/sa_feeder.md
SA_FEEDER -- requirements
Module: sa_feeder

Interface
REQ-001 Parameter DW, default 8, data width of every matrix element and output lane.
REQ-002 Parameter DRAIN_CYCLES, default 4, cycles held in DRAIN after the last activation is issued.
REQ-003 Port clk  input  1  single clock for all state; rising-edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request to process one job; sampled only in IDLE.
REQ-006 Port w_flat  input  9*DW  weight matrix W[r][c], element r*3+c at bits [(r*3+c)*DW +: DW].
REQ-007 Port a_flat  input  9*DW  activation matrix A[r][c], same packing as w_flat.
REQ-008 Port busy  output  1  high in every state except IDLE.
REQ-009 Port done  output  1  one-cycle pulse when the job completes.
REQ-010 Port B_out_1, B_out_2, B_out_3  output  DW each  weight lanes to the array's B inputs.
REQ-011 Port P1_en  output  1  weight preload enable to the array.
REQ-012 Port A_out_1, A_out_2, A_out_3  output  DW each  skewed activation lanes to the array's A inputs.

Function
REQ-013 FSM states: IDLE, LOAD_W, FEED_A, DRAIN, DONE; one-hot or binary encoding is permitted.
REQ-014 IDLE with start=1: capture w_flat and a_flat into internal registers; next state LOAD_W.
REQ-015 start while busy=1 is ignored; captured matrices stay unchanged until the next accepted start.
REQ-016 LOAD_W lasts exactly 3 cycles, i=0..2: P1_en=1, B_out_k=W[i][k-1]; after i=2, next state FEED_A.
REQ-017 Outside LOAD_W, P1_en=0 and B_out_1..3=0.
REQ-018 FEED_A lasts exactly 5 cycles, t=0..4: A_out_k=A[t-(k-1)][k-1] when 0<=t-(k-1)<=2, else 0 (column k skewed by k-1 cycles).
REQ-019 Outside FEED_A, A_out_1..3=0.
REQ-020 All outputs are registered; values listed for state S appear on the outputs during the cycles the FSM is in S.
REQ-021 DRAIN lasts DRAIN_CYCLES cycles with all lanes 0, then DONE.
REQ-022 DONE lasts one cycle with done=1, then IDLE; start in the DONE cycle is ignored.
REQ-023 Total latency from the accepted start edge to the done pulse: 3+5+DRAIN_CYCLES+1 cycles; back-to-back jobs are separated by at least one IDLE cycle.
REQ-024 DRAIN_CYCLES=0: FEED_A goes directly to DONE.
REQ-025 Values are passed through unchanged; no arithmetic, sign or width conversion.

Reset
REQ-026 rst=0 asynchronously forces IDLE, busy=0, done=0, P1_en=0, all B_out and A_out lanes 0, counters 0, captured matrices 0.
REQ-027 Reset asserted in any state aborts the job; no done pulse is produced for it.
REQ-028 After rst deasserts, the first start is accepted on the first rising edge it is sampled high.

Structure
REQ-029 A shared package holds the FSM state type, the array dimension constant N=3, and the LOAD_W and FEED_A cycle counts (N and 2N-1).
REQ-030 One sub-module, sa_skew_lane, is instantiated per A lane: a DW-wide delay chain of configurable depth (0, 1, 2) with async active-low clear.
REQ-031 A single phase counter, wide enough for max(5, DRAIN_CYCLES), is shared by all timed states.

Verification
REQ-032 Reset, then start with W=1..9 row-major -> P1_en high for 3 cycles; B lanes (1,2,3), (4,5,6), (7,8,9); done exactly 13 cycles after the start edge with the default DRAIN_CYCLES.
REQ-033 A=diag(1,2,3) -> A_out_1=1 at FEED_A t=0, A_out_2=2 at t=2, A_out_3=3 at t=4; all other lane samples 0.
REQ-034 start pulsed during LOAD_W and during DRAIN with different matrices -> ignored; outputs match the first job and there is exactly one done pulse.
REQ-035 rst driven low mid-FEED_A -> all outputs 0 immediately (asynchronous), no done pulse; a fresh job after release completes correctly.
REQ-036 start held high continuously -> jobs run back-to-back, each separated by exactly one IDLE cycle, busy low only in that cycle.
